// File: rtl/rv32_pkg.sv
// Shared RV32I control types: selector enums, the per-stage control bundle
// and small decode helpers used by the pipeline control unit.
package rv32_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} ImmSel_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_BSEL, ALU_JALR
  } ALUSel_t;

  typedef enum logic [1:0] {WB_MEM, WB_ALU, WB_PC4} WBSel_t;

  typedef enum logic {PC_PC4, PC_ALU} PCSel_t;

  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10} fwd_sel_t;

  typedef struct packed {
    ImmSel_t ImmSel;
    logic    BrUn;
    logic    ASel;
    logic    BSel;
    ALUSel_t ALUSel;
    logic    MemRW;
    logic    RegWEn;
    WBSel_t  WBSel;
    logic    is_load;
    logic    is_branch;
    logic    is_jump;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '{
    ImmSel: IMM_I, BrUn: 1'b0, ASel: 1'b0, BSel: 1'b0, ALUSel: ALU_ADD,
    MemRW: 1'b0, RegWEn: 1'b0, WBSel: WB_ALU,
    is_load: 1'b0, is_branch: 1'b0, is_jump: 1'b0
  };

  function automatic ALUSel_t alu_op(input logic [2:0] f3, input logic alt);
    ALUSel_t op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    t = 1'b0;
    case (f3)
      3'b000:         t = eq;
      3'b001:         t = !eq;
      3'b100, 3'b110: t = lt;
      3'b101, 3'b111: t = !lt;
      default:        t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I decoder: instruction word to control bundle, register
// indices (zeroed when the operand is not read) and an illegal-opcode flag.
module ctrl_decode
  import rv32_pkg::*;
#(
  parameter int REGADDR_W  = 5,
  parameter bit ILLEGAL_EN = 1'b1
) (
  input  logic [31:0]          instr,
  output ctrl_bundle_t         ctrl,
  output logic [REGADDR_W-1:0] rd,
  output logic [REGADDR_W-1:0] rs1,
  output logic [REGADDR_W-1:0] rs2,
  output logic                 illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       use_rs1, use_rs2, known;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign f3          = instr[14:12];
  assign unused_bits = ^{instr[31], instr[29:25]};

  always_comb begin
    ctrl    = CTRL_NOP;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    known   = 1'b1;
    case (opcode)
      OP_R: begin
        ctrl.RegWEn = 1'b1;
        ctrl.ALUSel = alu_op(f3, instr[30]);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IMM: begin
        ctrl.BSel   = 1'b1;
        ctrl.RegWEn = 1'b1;
        ctrl.ALUSel = alu_op(f3, (f3 == 3'b101) && instr[30]);
        use_rs1 = 1'b1;
      end
      OP_LOAD: begin
        ctrl.BSel    = 1'b1;
        ctrl.RegWEn  = 1'b1;
        ctrl.WBSel   = WB_MEM;
        ctrl.is_load = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_STORE: begin
        ctrl.ImmSel = IMM_S;
        ctrl.BSel   = 1'b1;
        ctrl.MemRW  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.ImmSel    = IMM_B;
        ctrl.ASel      = 1'b1;
        ctrl.BSel      = 1'b1;
        ctrl.BrUn      = f3[2] & f3[1];
        ctrl.is_branch = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_JAL: begin
        ctrl.ImmSel  = IMM_J;
        ctrl.ASel    = 1'b1;
        ctrl.BSel    = 1'b1;
        ctrl.RegWEn  = 1'b1;
        ctrl.WBSel   = WB_PC4;
        ctrl.is_jump = 1'b1;
      end
      OP_JALR: begin
        ctrl.BSel    = 1'b1;
        ctrl.ALUSel  = ALU_JALR;
        ctrl.RegWEn  = 1'b1;
        ctrl.WBSel   = WB_PC4;
        ctrl.is_jump = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_LUI: begin
        ctrl.ImmSel = IMM_U;
        ctrl.BSel   = 1'b1;
        ctrl.ALUSel = ALU_BSEL;
        ctrl.RegWEn = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.ImmSel = IMM_U;
        ctrl.ASel   = 1'b1;
        ctrl.BSel   = 1'b1;
        ctrl.RegWEn = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: known = 1'b1;
      default: known = 1'b0;
    endcase
    // x0 is never a write target, which also keeps it out of hazard and forward matching
    if (instr[11:7] == 5'd0) ctrl.RegWEn = 1'b0;
  end

  assign illegal = ILLEGAL_EN && !known;
  assign rd      = REGADDR_W'(instr[11:7]);
  assign rs1     = use_rs1 ? REGADDR_W'(instr[19:15]) : '0;
  assign rs2     = use_rs2 ? REGADDR_W'(instr[24:20]) : '0;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control for the 5-stage RV32I core: carries decoded control through
// ID/EX, EX/MEM and MEM/WB, resolves branches, and generates stall/flush/forward.
module pipe_ctrl_unit
  import rv32_pkg::*;
#(
  parameter int REGADDR_W  = 5,
  parameter bit FWD_EN     = 1'b1,
  parameter bit ILLEGAL_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [31:0]          id_instr,
  input  logic                 ex_BrEq,
  input  logic                 ex_BrLT,
  input  logic                 stall_ext,
  output logic [2:0]           id_ImmSel,
  output logic                 ex_BrUn,
  output logic                 ex_ASel,
  output logic                 ex_BSel,
  output logic [3:0]           ex_ALUSel,
  output logic [1:0]           ex_fwd_a,
  output logic [1:0]           ex_fwd_b,
  output logic                 PCSel,
  output logic                 pc_hold,
  output logic                 ifid_flush,
  output logic                 mem_MemRW,
  output logic                 wb_RegWEn,
  output logic [1:0]           wb_WBSel,
  output logic [REGADDR_W-1:0] wb_rd,
  output logic                 illegal_o
);

  typedef struct packed {
    logic                 valid;
    ctrl_bundle_t         ctrl;
    logic [REGADDR_W-1:0] rd;
    logic [REGADDR_W-1:0] rs1;
    logic [REGADDR_W-1:0] rs2;
    logic [2:0]           funct3;
    logic                 illegal;
  } stage_t;

  localparam stage_t BUBBLE = '{valid: 1'b0, ctrl: CTRL_NOP, rd: '0, rs1: '0,
                                rs2: '0, funct3: 3'b0, illegal: 1'b0};

  stage_t idex, exmem, memwb, id_stage;
  ctrl_bundle_t id_ctrl, ex_ctrl, mem_ctrl, wb_ctrl;
  logic [REGADDR_W-1:0] id_rd, id_rs1, id_rs2;
  logic id_illegal, redirect, load_use, raw_stall, hazard;
  logic unused_state;

  ctrl_decode #(.REGADDR_W(REGADDR_W), .ILLEGAL_EN(ILLEGAL_EN)) u_decode (
    .instr(id_instr), .ctrl(id_ctrl), .rd(id_rd), .rs1(id_rs1), .rs2(id_rs2),
    .illegal(id_illegal)
  );

  function automatic logic hits(input stage_t s, input logic [REGADDR_W-1:0] r);
    return s.valid && s.ctrl.RegWEn && (s.rd != '0) && (s.rd == r);
  endfunction

  function automatic fwd_sel_t fwd_for(input logic [REGADDR_W-1:0] r);
    fwd_sel_t f;
    f = FWD_RF;
    if (FWD_EN && idex.valid) begin
      if (hits(exmem, r))      f = FWD_MEM;
      else if (hits(memwb, r)) f = FWD_WB;
    end
    return f;
  endfunction

  always_comb begin
    id_stage = '{valid: 1'b1, ctrl: id_ctrl, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
                 funct3: id_instr[14:12], illegal: id_illegal};
    redirect = idex.valid && (idex.ctrl.is_jump ||
               (idex.ctrl.is_branch && branch_taken(idex.funct3, ex_BrEq, ex_BrLT)));
    load_use = id_valid && idex.ctrl.is_load &&
               (hits(idex, id_rs1) || hits(idex, id_rs2));
    // without forwarding, anything still in EX or MEM is invisible to ID; WB writes through
    raw_stall = !FWD_EN && id_valid &&
                (hits(idex, id_rs1) || hits(idex, id_rs2) ||
                 hits(exmem, id_rs1) || hits(exmem, id_rs2));
    hazard = load_use || raw_stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex  <= BUBBLE;
      exmem <= BUBBLE;
      memwb <= BUBBLE;
    end else if (!stall_ext) begin
      idex  <= (redirect || hazard || !id_valid) ? BUBBLE : id_stage;
      exmem <= idex;
      memwb <= exmem;
    end
  end

  assign ex_ctrl  = idex.valid  ? idex.ctrl  : CTRL_NOP;
  assign mem_ctrl = exmem.valid ? exmem.ctrl : CTRL_NOP;
  assign wb_ctrl  = memwb.valid ? memwb.ctrl : CTRL_NOP;

  assign id_ImmSel  = id_ctrl.ImmSel;
  assign ex_BrUn    = ex_ctrl.BrUn;
  assign ex_ASel    = ex_ctrl.ASel;
  assign ex_BSel    = ex_ctrl.BSel;
  assign ex_ALUSel  = ex_ctrl.ALUSel;
  assign ex_fwd_a   = fwd_for(idex.rs1);
  assign ex_fwd_b   = fwd_for(idex.rs2);
  // a redirect squashes the hazard-stalled ID instruction, so it also releases the hold
  assign PCSel      = (redirect && !stall_ext) ? PC_ALU : PC_PC4;
  assign ifid_flush = redirect && !stall_ext;
  assign pc_hold    = stall_ext || (hazard && !redirect);
  assign mem_MemRW  = mem_ctrl.MemRW;
  assign wb_RegWEn  = wb_ctrl.RegWEn;
  assign wb_WBSel   = wb_ctrl.WBSel;
  assign wb_rd      = memwb.valid ? memwb.rd : '0;
  assign illegal_o  = idex.valid && idex.illegal && !stall_ext;

  assign unused_state = ^{idex, exmem, memwb, ex_ctrl, mem_ctrl, wb_ctrl};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: a forwarding instance (a_*) and a
// no-forwarding instance (n_*) share one stimulus stream.
`timescale 1ns/1ps
module tb_pipe_ctrl_unit;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic rst, id_valid, ex_BrEq, ex_BrLT, stall_ext;
  logic [31:0] id_instr;

  logic [2:0] a_id_ImmSel, n_id_ImmSel;
  logic a_ex_BrUn, a_ex_ASel, a_ex_BSel, n_ex_BrUn, n_ex_ASel, n_ex_BSel;
  logic [3:0] a_ex_ALUSel, n_ex_ALUSel;
  logic [1:0] a_ex_fwd_a, a_ex_fwd_b, n_ex_fwd_a, n_ex_fwd_b, a_wb_WBSel, n_wb_WBSel;
  logic a_PCSel, a_pc_hold, a_ifid_flush, a_mem_MemRW, a_wb_RegWEn, a_illegal_o;
  logic n_PCSel, n_pc_hold, n_ifid_flush, n_mem_MemRW, n_wb_RegWEn, n_illegal_o;
  logic [4:0] a_wb_rd, n_wb_rd;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.REGADDR_W(5), .FWD_EN(1'b1), .ILLEGAL_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .ex_BrEq(ex_BrEq), .ex_BrLT(ex_BrLT), .stall_ext(stall_ext),
    .id_ImmSel(a_id_ImmSel), .ex_BrUn(a_ex_BrUn), .ex_ASel(a_ex_ASel),
    .ex_BSel(a_ex_BSel), .ex_ALUSel(a_ex_ALUSel), .ex_fwd_a(a_ex_fwd_a),
    .ex_fwd_b(a_ex_fwd_b), .PCSel(a_PCSel), .pc_hold(a_pc_hold),
    .ifid_flush(a_ifid_flush), .mem_MemRW(a_mem_MemRW), .wb_RegWEn(a_wb_RegWEn),
    .wb_WBSel(a_wb_WBSel), .wb_rd(a_wb_rd), .illegal_o(a_illegal_o)
  );

  pipe_ctrl_unit #(.REGADDR_W(5), .FWD_EN(1'b0), .ILLEGAL_EN(1'b1)) dut_n (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .ex_BrEq(ex_BrEq), .ex_BrLT(ex_BrLT), .stall_ext(stall_ext),
    .id_ImmSel(n_id_ImmSel), .ex_BrUn(n_ex_BrUn), .ex_ASel(n_ex_ASel),
    .ex_BSel(n_ex_BSel), .ex_ALUSel(n_ex_ALUSel), .ex_fwd_a(n_ex_fwd_a),
    .ex_fwd_b(n_ex_fwd_b), .PCSel(n_PCSel), .pc_hold(n_pc_hold),
    .ifid_flush(n_ifid_flush), .mem_MemRW(n_mem_MemRW), .wb_RegWEn(n_wb_RegWEn),
    .wb_WBSel(n_wb_WBSel), .wb_rd(n_wb_rd), .illegal_o(n_illegal_o)
  );

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  // One cycle of stimulus: inputs change on the falling edge, outputs are read 1ns later
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] ins,
      input logic eq, input logic lt, input logic sx);
    @(negedge clk);
    rst = r; id_valid = v; id_instr = ins; ex_BrEq = eq; ex_BrLT = lt; stall_ext = sx;
    #1;
  endtask

  task automatic run(input logic v, input logic [31:0] ins);
    applyStimulus(1'b0, v, ins, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  imm;
    logic [3:0]  alu;
    logic        asel;
    logic        bsel;
    logic        brun;
  } dec_vec_t;

  typedef struct {
    logic [2:0] f3;
    logic       eq;
    logic       lt;
    logic       taken;
  } br_vec_t;

  dec_vec_t dtab[14];
  br_vec_t  btab[12];

  localparam logic [31:0] ADDI_X1 = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] ADD_X2  = 32'h00108133;  // add  x2,x1,x1
  localparam logic [31:0] LW_X3   = 32'h00002183;  // lw   x3,0(x0)
  localparam logic [31:0] ADD_X4  = 32'h00018233;  // add  x4,x3,x0
  localparam logic [31:0] BEQ_8   = 32'h00000463;  // beq  x0,x0,+8
  localparam logic [31:0] SW_0    = 32'h00002023;  // sw   x0,0(x0)

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_instr = 32'h0; ex_BrEq = 1'b0; ex_BrLT = 1'b0; stall_ext = 1'b0;

    dtab[0]  = '{enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2),          IMM_I, ALU_ADD,  1'b0, 1'b0, 1'b0};
    dtab[1]  = '{enc_r(7'h20, 5'd7, 5'd6, 3'b000, 5'd5),          IMM_I, ALU_SUB,  1'b0, 1'b0, 1'b0};
    dtab[2]  = '{enc_r(7'h00, 5'd7, 5'd6, 3'b011, 5'd5),          IMM_I, ALU_SLTU, 1'b0, 1'b0, 1'b0};
    dtab[3]  = '{ADDI_X1,                                          IMM_I, ALU_ADD,  1'b0, 1'b1, 1'b0};
    dtab[4]  = '{enc_i(12'h403, 5'd2, 3'b101, 5'd1, 7'h13),       IMM_I, ALU_SRA,  1'b0, 1'b1, 1'b0};
    dtab[5]  = '{enc_i(12'h001, 5'd2, 3'b100, 5'd1, 7'h13),       IMM_I, ALU_XOR,  1'b0, 1'b1, 1'b0};
    dtab[6]  = '{LW_X3,                                            IMM_I, ALU_ADD,  1'b0, 1'b1, 1'b0};
    dtab[7]  = '{enc_s(12'd4, 5'd5, 5'd6, 3'b010),                IMM_S, ALU_ADD,  1'b0, 1'b1, 1'b0};
    dtab[8]  = '{enc_b(13'd8, 5'd2, 5'd1, 3'b110),                IMM_B, ALU_ADD,  1'b1, 1'b1, 1'b1};
    dtab[9]  = '{enc_b(13'd8, 5'd2, 5'd1, 3'b100),                IMM_B, ALU_ADD,  1'b1, 1'b1, 1'b0};
    dtab[10] = '{enc_j(21'd16, 5'd1),                              IMM_J, ALU_ADD,  1'b1, 1'b1, 1'b0};
    dtab[11] = '{enc_i(12'h000, 5'd5, 3'b000, 5'd1, 7'h67),       IMM_I, ALU_JALR, 1'b0, 1'b1, 1'b0};
    dtab[12] = '{{20'h12345, 5'd3, 7'h37},                         IMM_U, ALU_BSEL, 1'b0, 1'b1, 1'b0};
    dtab[13] = '{{20'h00001, 5'd4, 7'h17},                         IMM_U, ALU_ADD,  1'b1, 1'b1, 1'b0};

    btab[0]  = '{3'b000, 1'b1, 1'b0, 1'b1};
    btab[1]  = '{3'b000, 1'b0, 1'b0, 1'b0};
    btab[2]  = '{3'b001, 1'b0, 1'b0, 1'b1};
    btab[3]  = '{3'b001, 1'b1, 1'b0, 1'b0};
    btab[4]  = '{3'b100, 1'b0, 1'b1, 1'b1};
    btab[5]  = '{3'b101, 1'b0, 1'b1, 1'b0};
    btab[6]  = '{3'b101, 1'b0, 1'b0, 1'b1};
    btab[7]  = '{3'b110, 1'b0, 1'b1, 1'b1};
    btab[8]  = '{3'b111, 1'b0, 1'b0, 1'b1};
    btab[9]  = '{3'b111, 1'b0, 1'b1, 1'b0};
    btab[10] = '{3'b010, 1'b1, 1'b1, 1'b0};
    btab[11] = '{3'b011, 1'b1, 1'b1, 1'b0};

    // Reset state
    doReset();
    run(1'b0, 32'h0);
    checkOutput("rst_PCSel", a_PCSel, PC_PC4);
    checkOutput("rst_pc_hold", a_pc_hold, 0);
    checkOutput("rst_ifid_flush", a_ifid_flush, 0);
    checkOutput("rst_fwd", {a_ex_fwd_a, a_ex_fwd_b}, 0);
    checkOutput("rst_MemRW", a_mem_MemRW, 0);
    checkOutput("rst_RegWEn", a_wb_RegWEn, 0);
    checkOutput("rst_wb_rd", a_wb_rd, 0);
    checkOutput("rst_illegal", a_illegal_o, 0);

    // Decode table: ImmSel in ID, then EX controls one cycle later
    for (int i = 0; i < 14; i++) begin
      run(1'b1, dtab[i].instr);
      checkOutput($sformatf("dec%0d_ImmSel", i), a_id_ImmSel, dtab[i].imm);
      run(1'b0, 32'h0);
      checkOutput($sformatf("dec%0d_ALUSel", i), a_ex_ALUSel, dtab[i].alu);
      checkOutput($sformatf("dec%0d_ASel", i), a_ex_ASel, dtab[i].asel);
      checkOutput($sformatf("dec%0d_BSel", i), a_ex_BSel, dtab[i].bsel);
      checkOutput($sformatf("dec%0d_BrUn", i), a_ex_BrUn, dtab[i].brun);
    end

    // Branch resolution table
    for (int i = 0; i < 12; i++) begin
      run(1'b1, enc_b(13'd8, 5'd0, 5'd0, btab[i].f3));
      applyStimulus(1'b0, 1'b0, 32'h0, btab[i].eq, btab[i].lt, 1'b0);
      checkOutput($sformatf("br%0d_PCSel", i), a_PCSel, btab[i].taken);
      checkOutput($sformatf("br%0d_flush", i), a_ifid_flush, btab[i].taken);
    end

    // EX/MEM forwarding back-to-back
    doReset();
    run(1'b1, ADDI_X1);
    run(1'b1, ADD_X2);
    checkOutput("fwd1_hold", a_pc_hold, 0);
    run(1'b0, 32'h0);
    checkOutput("fwd1_a", a_ex_fwd_a, FWD_MEM);
    checkOutput("fwd1_b", a_ex_fwd_b, FWD_MEM);
    run(1'b0, 32'h0);
    checkOutput("fwd1_wb1_we", a_wb_RegWEn, 1);
    checkOutput("fwd1_wb1_rd", a_wb_rd, 1);
    run(1'b0, 32'h0);
    checkOutput("fwd1_wb2_we", a_wb_RegWEn, 1);
    checkOutput("fwd1_wb2_rd", a_wb_rd, 2);

    // Load-use: one hold cycle, one bubble, then WB forwarding
    doReset();
    run(1'b1, LW_X3);
    run(1'b1, ADD_X4);
    checkOutput("lu_hold1", a_pc_hold, 1);
    run(1'b1, ADD_X4);
    checkOutput("lu_hold2", a_pc_hold, 0);
    run(1'b0, 32'h0);
    checkOutput("lu_fwd_a", a_ex_fwd_a, FWD_WB);
    checkOutput("lu_fwd_b", a_ex_fwd_b, FWD_RF);
    checkOutput("lu_wb_rd", a_wb_rd, 3);
    run(1'b0, 32'h0);
    checkOutput("lu_bubble_we", a_wb_RegWEn, 0);
    run(1'b0, 32'h0);
    checkOutput("lu_add_we", a_wb_RegWEn, 1);
    checkOutput("lu_add_rd", a_wb_rd, 4);

    // Taken beq: redirect, two dead slots, then a not-taken beq
    doReset();
    run(1'b1, BEQ_8);
    applyStimulus(1'b0, 1'b1, ADDI_X1, 1'b1, 1'b0, 1'b0);
    checkOutput("beq_PCSel", a_PCSel, PC_ALU);
    checkOutput("beq_flush", a_ifid_flush, 1);
    run(1'b0, 32'h0);
    checkOutput("beq_PCSel_after", a_PCSel, PC_PC4);
    checkOutput("beq_flush_after", a_ifid_flush, 0);
    run(1'b0, 32'h0);
    checkOutput("beq_wb_branch_we", a_wb_RegWEn, 0);
    run(1'b0, 32'h0);
    checkOutput("beq_slot1_we", a_wb_RegWEn, 0);
    run(1'b1, BEQ_8);
    checkOutput("beq_slot2_we", a_wb_RegWEn, 0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("beq_nt_PCSel", a_PCSel, PC_PC4);

    // RAW stall in the no-forward instance coinciding with a taken branch
    doReset();
    run(1'b1, enc_i(12'd1, 5'd0, 3'b000, 5'd6, 7'h13));
    run(1'b1, BEQ_8);
    checkOutput("rr_pre_hold", n_pc_hold, 0);
    applyStimulus(1'b0, 1'b1, enc_r(7'h00, 5'd0, 5'd6, 3'b000, 5'd7), 1'b1, 1'b0, 1'b0);
    checkOutput("rr_hold", n_pc_hold, 0);
    checkOutput("rr_flush", n_ifid_flush, 1);
    checkOutput("rr_PCSel", n_PCSel, PC_ALU);
    run(1'b0, 32'h0);
    checkOutput("rr_hold_after", n_pc_hold, 0);
    checkOutput("rr_flush_after", n_ifid_flush, 0);

    // External stall with a jump in EX, then reset in the middle of a stall
    doReset();
    run(1'b1, ADDI_X1);
    run(1'b1, enc_i(12'd7, 5'd0, 3'b000, 5'd2, 7'h13));
    run(1'b1, enc_j(21'd16, 5'd3));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("sx%0d_wb_rd", k), a_wb_rd, 1);
      checkOutput($sformatf("sx%0d_we", k), a_wb_RegWEn, 1);
      checkOutput($sformatf("sx%0d_PCSel", k), a_PCSel, PC_PC4);
      checkOutput($sformatf("sx%0d_flush", k), a_ifid_flush, 0);
    end
    run(1'b0, 32'h0);
    checkOutput("sx_resume_rd", a_wb_rd, 1);
    checkOutput("sx_resume_PCSel", a_PCSel, PC_ALU);
    run(1'b0, 32'h0);
    checkOutput("sx_next_rd", a_wb_rd, 2);
    run(1'b0, 32'h0);
    checkOutput("sx_jal_rd", a_wb_rd, 3);
    checkOutput("sx_jal_WBSel", a_wb_WBSel, WB_PC4);
    run(1'b1, enc_i(12'd1, 5'd0, 3'b000, 5'd4, 7'h13));
    run(1'b1, SW_0);
    run(1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("sr_MemRW", a_mem_MemRW, 1);
    checkOutput("sr_wb_rd", a_wb_rd, 4);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    run(1'b0, 32'h0);
    checkOutput("sr_MemRW_after", a_mem_MemRW, 0);
    checkOutput("sr_we_after", a_wb_RegWEn, 0);
    checkOutput("sr_rd_after", a_wb_rd, 0);
    run(1'b0, 32'h0);
    checkOutput("sr_MemRW_after2", a_mem_MemRW, 0);
    checkOutput("sr_we_after2", a_wb_RegWEn, 0);

    // No-forward instance: back-to-back RAW costs two stall cycles
    doReset();
    run(1'b1, ADDI_X1);
    run(1'b1, ADD_X2);
    checkOutput("nf_hold1", n_pc_hold, 1);
    run(1'b1, ADD_X2);
    checkOutput("nf_hold2", n_pc_hold, 1);
    run(1'b1, ADD_X2);
    checkOutput("nf_hold3", n_pc_hold, 0);
    checkOutput("nf_wb_rd_addi", n_wb_rd, 1);
    run(1'b0, 32'h0);
    checkOutput("nf_fwd_a", n_ex_fwd_a, FWD_RF);
    checkOutput("nf_fwd_b", n_ex_fwd_b, FWD_RF);
    run(1'b0, 32'h0);
    checkOutput("nf_bubble_we", n_wb_RegWEn, 0);
    run(1'b0, 32'h0);
    checkOutput("nf_add_rd", n_wb_rd, 2);
    checkOutput("nf_add_we", n_wb_RegWEn, 1);

    // Illegal opcode with rd = x31: one-cycle pulse in EX, never writes
    doReset();
    run(1'b1, 32'h00000FFF);
    checkOutput("ill_in_id", a_illegal_o, 0);
    run(1'b0, 32'h0);
    checkOutput("ill_pulse", a_illegal_o, 1);
    run(1'b0, 32'h0);
    checkOutput("ill_pulse_end", a_illegal_o, 0);
    run(1'b0, 32'h0);
    checkOutput("ill_wb_we", a_wb_RegWEn, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Pipelined successor to the single-cycle control decoder for the 5-stage RV32I core.
- Decodes the ID-stage instruction and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Resolves branches and jumps in EX and drives PCSel.
- Detects load-use and RAW hazards, and generates stall, flush and forwarding selects.
- Owns all pipeline control state; the datapath holds only data registers.

Parameters:
REGADDR_W, 5, register index width.
FWD_EN, 1, 1 = EX-stage forwarding from MEM/WB; 0 = no forwarding, stall on every RAW hazard.
ILLEGAL_EN, 1, 1 = flag unknown opcodes on illegal_o and squash them; 0 = treat them as NOP silently.

Ports:
clk  in  1  core clock.
rst  in  1  synchronous reset, active-high.
id_valid  in  1  IF/ID register holds a valid instruction.
id_instr  in  32  instruction in ID.
ex_BrEq  in  1  branch comparator equal, EX stage.
ex_BrLT  in  1  branch comparator less-than, EX stage.
stall_ext  in  1  external freeze (memory wait); holds the whole pipe.
id_ImmSel  out  3  ImmSel_t for ImmGen in ID (combinational).
ex_BrUn  out  1  unsigned compare, EX.
ex_ASel  out  1  A operand select, EX.
ex_BSel  out  1  B operand select, EX.
ex_ALUSel  out  4  ALUSel_t, EX.
ex_fwd_a  out  2  A forward select: 00 regfile, 01 EX/MEM ALU, 10 WB value.
ex_fwd_b  out  2  B forward select, same encoding.
PCSel  out  1  PCSel_t: PC_PC4 or PC_ALU (redirect).
pc_hold  out  1  hold PC and IF/ID.
ifid_flush  out  1  invalidate IF/ID at next edge.
mem_MemRW  out  1  data memory write, MEM.
wb_RegWEn  out  1  regfile write, WB.
wb_WBSel  out  2  WBSel_t, WB.
wb_rd  out  REGADDR_W  destination register, WB.
illegal_o  out  1  pulse: illegal opcode entered EX.

Behaviour:
Decode:
- Decode mapping identical to the single-cycle decoder, with these fixes: JALR gives WBSel = WB_PC4 and ALUSel = ALU_JALR; branches give ASel = 1, BSel = 1, ALU_ADD; BrUn = 1 for BLTU/BGEU only.
- rd = instr[11:7]; rs1 = instr[19:15]; rs2 = instr[24:20].
- rs1 is used by R, I_ALU, LOAD, S, B, JALR.
- rs2 is used by R, S, B.
- RegWEn is forced to 0 when rd == 0.

Stage registers:
- Each of ID/EX, EX/MEM and MEM/WB holds: valid, control bundle, rd, rs1, rs2, is_load, is_branch, is_jump, funct3.
- All outputs are driven from the stage register only when its valid is set; otherwise they take their safe values.
- Safe values: RegWEn = 0, MemRW = 0, PCSel = PC_PC4.

Reset:
- All stage valids = 0.
- Output values after reset: PCSel = PC_PC4; pc_hold = 0; ifid_flush = 0; fwd = 00; MemRW = 0; RegWEn = 0; wb_rd = 0; illegal_o = 0.
- Reset asserted mid-operation clears every valid at the next edge. No partial writes: MemRW/RegWEn are 0 from the cycle after the reset edge.

Branch resolution (EX, combinational on ID/EX):
- taken = BEQ: BrEq; BNE: !BrEq; BLT/BLTU: BrLT; BGE/BGEU: !BrLT.
- Any unlisted funct3 is not taken.
- Redirect when ID/EX is valid and (is_jump, or is_branch && taken).
- On redirect: PCSel = PC_ALU and ifid_flush = 1; at the next edge ID/EX loads a bubble (2-cycle penalty).

Load-use hazard:
- Condition: ID/EX is a valid load, rd != 0, and rd matches a used rs of a valid ID instruction.
- Response: pc_hold = 1, IF/ID is held, ID/EX loads a bubble; 1 bubble.

FWD_EN = 0:
- Stall (same action as load-use) when a used rs matches a valid writing rd in ID/EX or EX/MEM.
- The regfile is write-through, so WB needs no stall.

Priority per edge:
1. rst
2. stall_ext: all registers hold; PCSel = PC_PC4; ifid_flush = 0
3. redirect: overrides the load-use stall and clears pc_hold
4. hazard stall
5. normal advance

Forwarding (FWD_EN = 1, evaluated for the ID/EX rs1/rs2):
- 01 when EX/MEM is valid, RegWEn = 1, rd != 0, rd == rs.
- Else 10 when MEM/WB matches under the same conditions.
- Else 00.
- EX/MEM takes priority over MEM/WB.
- FWD_EN = 0 forces 00.

Illegal opcode (ILLEGAL_EN = 1):
- Enters ID/EX with RegWEn = 0 and MemRW = 0.
- illegal_o pulses high for one cycle while it is in EX and not flushed.

Decomposition:
- rv32_pkg gains: ctrl_bundle_t (packed struct: ImmSel, BrUn, ASel, BSel, ALUSel, MemRW, RegWEn, WBSel, is_load, is_branch, is_jump).
- rv32_pkg also gains: CTRL_NOP constant (safe bubble values) and fwd_sel_t enum (FWD_RF, FWD_MEM, FWD_WB).
- Sub-module ctrl_decode: combinational instr → ctrl_bundle_t + illegal. This is the existing decoder refactored to emit the struct.
- pipe_ctrl_unit instantiates ctrl_decode once.

Test Plan:
1. addi x1,x0,5 then add x2,x1,x1 back-to-back → in the add's EX cycle fwd_a = fwd_b = 01; no stall; wb_rd = 2 with RegWEn two cycles later.
2. lw x3,0(x0) then add x4,x3,x0 → pc_hold = 1 for exactly 1 cycle, one bubble (RegWEn = 0) appears in WB, then fwd_a = 10 for the add.
3. beq x0,x0,+8 (ex_BrEq = 1) → PCSel = PC_ALU and ifid_flush = 1 for 1 cycle; the next 2 slots reach WB with RegWEn = 0. Same beq with ex_BrEq = 0 → PCSel stays PC_PC4.
4. Load-use hazard in the same cycle as a taken branch in EX → redirect wins: pc_hold = 0, ifid_flush = 1, no extra bubble.
5. stall_ext high for 3 cycles mid-stream → all WB outputs frozen, PCSel = PC_PC4; the stream resumes unchanged. rst asserted in the middle of the stall → next cycle RegWEn = 0, MemRW = 0, all valids clear.
6. FWD_EN = 0 rerun of scenario 1 → 2 stall cycles, fwd = 00. Opcode 7'h7F with ILLEGAL_EN = 1 → illegal_o pulses 1 cycle, no register write.
